// File: rtl/simple_io_pkg.sv
// Shared constants and types for the SimpleIO AXI4-Lite register bank.
package simple_io_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;

  localparam logic [1:0] REG_IO   = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_2    = 2'd2;
  localparam logic [1:0] REG_3    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WS_IDLE,
    WS_RESP
  } wr_state_e;

endpackage

// File: rtl/simple_io_wstrb_merge.sv
// Byte-lane merge of a register's old value with new write data under WSTRB.
module simple_io_wstrb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  output logic [DW-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DW/8; b++) begin
      if (wstrb_i[b]) merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/simple_io_axil_regs.sv
// AXI4-Lite slave with four R/W registers for the SimpleIO peripheral.
// Define SIMPLEIO_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
//
//   state   | meaning
//   WS_IDLE | collecting AW and W into their holding slots; commits when both full
//   WS_RESP | write committed, BVALID high until BREADY
module simple_io_axil_regs
  import simple_io_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   io_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

`ifdef SIMPLEIO_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

  logic                ready_en_q;
  logic                aw_full_q;
  logic [2:0]          aw_idx_q;
  logic                w_full_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wstrb_q;
  wr_state_e           wr_state_q, wr_state_d;
  logic [1:0]          bresp_q;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic                rvalid_q;
  logic [DW-1:0]       rdata_q;
  logic [1:0]          rresp_q;

  logic                aw_hs, w_hs, ar_hs, commit, aw_mapped;
  logic [2:0]          ar_idx;
  logic [DW-1:0]       merged;
  logic                unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by a flag that only sets on the first edge after reset release.
  assign S_AXI_AWREADY = ready_en_q && !aw_full_q && (wr_state_q == WS_IDLE);
  assign S_AXI_WREADY  = ready_en_q && !w_full_q  && (wr_state_q == WS_IDLE);
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit    = (wr_state_q == WS_IDLE) && aw_full_q && w_full_q;
  assign aw_mapped = !aw_idx_q[2];
  assign ar_idx    = S_AXI_ARADDR[4:2];

  simple_io_wstrb_merge #(.DW(DW)) u_merge (
    .old_i    (regs_q[aw_idx_q[1:0]]),
    .wdata_i  (wdata_q),
    .wstrb_i  (wstrb_q),
    .merged_o (merged)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    wr_pulse_d = '0;
    case (wr_state_q)
      WS_IDLE: begin
        if (commit) begin
          wr_state_d = WS_RESP;
          if (aw_mapped) wr_pulse_d[aw_idx_q[1:0]] = 1'b1;
        end
      end
      WS_RESP: if (S_AXI_BREADY) wr_state_d = WS_IDLE;
      default: wr_state_d = WS_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      wr_state_q <= WS_IDLE;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      wr_state_q <= wr_state_d;
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= aw_mapped ? RESP_OKAY : UNMAPPED_RESP;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse_d[i]) regs_q[i] <= merged;
      end
    end
  end

  // Read samples regs_q before any same-edge commit, so it returns the pre-write value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_idx[2] ? '0 : regs_q[ar_idx[1:0]];
      rresp_q  <= ar_idx[2] ? UNMAPPED_RESP : RESP_OKAY;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = (wr_state_q == WS_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign io_out       = regs_q[REG_IO];
  assign ctrl_out     = regs_q[REG_CTRL];
  assign wr_pulse     = wr_pulse_q;

endmodule

// File: doc/simple_io_axil_regs.md
# simple_io_axil_regs

AXI4-Lite slave register bank that terminates the S00_AXI port of the SimpleIO peripheral, directly downstream of the AXI master agent/interconnect. It decodes four 32-bit read/write registers, applies byte strobes, and drives register contents and per-register write pulses out to the IO logic. Address and write-data channels are buffered independently, so masters may present them in any order.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 5, byte address width; registers at 0x00/0x04/0x08/0x0C, 0x10–0x1C unmapped
- S_AXI_ACLK  in  1  single clock, all logic rising-edge
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored
- S_AXI_WDATA/WSTRB/WVALID in, WREADY out  32/4/1/1  write data channel
- S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write response
- S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_WIDTH/3/1/1  read address; ARPROT ignored
- S_AXI_RDATA/RRESP/RVALID out, RREADY in  32/2/1/1  read data
- io_out  out  32  live value of register 0
- ctrl_out  out  32  live value of register 1
- wr_pulse  out  4  one-cycle strobe, bit i set the cycle register i is updated

## Operation
- Registers 0–3 all read/write; word index = AWADDR/ARADDR[4:2]; bits [1:0] ignored.
- Write path: AW holding slot and W holding slot, each one entry. AWREADY high while AW slot empty and no B pending; WREADY likewise for W slot.
- Commit: cycle after both slots full, register updated byte-wise per WSTRB (strobe 0 keeps old byte), wr_pulse[idx] high that cycle, both slots cleared, BVALID set same cycle.
- BVALID held until BREADY; no new AW/W accepted while BVALID high.
- Read path: ARREADY high when RVALID low. On AR handshake RDATA/RRESP registered, RVALID set next edge, held (data stable) until RREADY.
- Read and write channels independent. Same-register write commit and AR handshake in one cycle: read returns pre-write value.
- Unmapped index (4–7): write discarded, no wr_pulse; read data 0. Response per Configuration.

## Timing
- Reset (async, ARESETN low): all registers 0, io_out/ctrl_out 0, wr_pulse 0, AWREADY/WREADY/ARREADY 0 during reset, BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0, holding slots empty. Readies rise first edge after release.
- Reset mid-transaction: in-flight write dropped (register unchanged unless commit edge already passed), pending response lost.
- AW and W in same cycle: accepted edge N, commit+BVALID at N+1. Minimum write latency 2 cycles handshake-to-BVALID-visible; throughput one write per 3 cycles with BREADY tied high.
- AR handshake edge N: RVALID visible after N. Back-to-back reads: one per 2 cycles with RREADY high.
- W ahead of AW by k cycles: W held, WREADY low until commit.

## Configuration
- SIMPLEIO_SLVERR_EN defined: unmapped accesses return BRESP/RRESP = 2'b10 (SLVERR).
- Undefined: unmapped accesses return OKAY (2'b00); data behaviour identical.

## Structure
- Package simple_io_pkg: register index constants (REG_IO=0, REG_CTRL=1, REG_2, REG_3), NUM_REGS=4, RESP_OKAY/RESP_SLVERR localparams, write-channel state enum.
- One sub-module: simple_io_wstrb_merge (combinational byte-merge of old value, WDATA, WSTRB); everything else in top.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC, read back in order -> RDATA 0x1..0x4, all RESP OKAY, io_out=0x1, ctrl_out=0x2.
- Write 0xAABBCCDD to 0x0 then 0x11223344 with WSTRB=4'b0101 -> read 0x0 = 0xAA22CC44, wr_pulse=4'b0001 each commit.
- W presented 3 cycles before AW at 0x8 -> WREADY drops after W accepted, single commit after AW, BVALID once, reg2 updated.
- BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY low, next write stalls until B handshake.
- Write 0x5 and read 0x14 -> write discarded, read 0; RESP SLVERR with SIMPLEIO_SLVERR_EN, OKAY without.
- Assert ARESETN low mid-read with RVALID high -> RVALID, registers, io_out return to 0 immediately (asynchronous).
